acumulador_rizado: RTL

ACUMULADOR_RIZADO -- requirements
Module: acumulador_rizado

---
 rtl/acumulador_rizado.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/acumulador_rizado.sv
// Ripple-carry accumulator: one 8-bit ripple adder fed from operand registers, sampled after a settle window.
// Latency: result valid WAIT_CYC edges after acceptance, then held until downstream takes it.
// Backpressure: in_ready low outside IDLE (and while clear is high); out_valid holds until out_ready.

// Plain 8-bit ripple-carry adder built from a chain of full-adder cells.
// PwrC is a tag for power-count flows. It rides along with the instance and
// never changes the cell count, the chain length or the function.
module SUM_RIZADO #(
    parameter int PwrC = 0
) (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);

    // The tag folds into the width expression as zero, so it stays referenced
    // without affecting the arithmetic.
    localparam int W = 8 + (PwrC * 0);

    logic [W:0] w_c;

    assign w_c[0] = i_cin;

    // One full-adder cell per bit; each carry feeds the next cell.
    for (genvar gi = 0; gi < W; gi++) begin : g_fa
        assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
        assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
    end

    assign o_cout = w_c[W];

endmodule

module acumulador_rizado #(
    parameter int PwrC     = 0,
    parameter int WAIT_CYC = 2
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    input  logic       cin,
    input  logic       acc_mode,
    input  logic       clear,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] result,
    output logic       carry_out,
    output logic [3:0] ovf_cnt
);

    // Settle counter preload: with WAIT_CYC=N the adder output is sampled on
    // the N-th edge after acceptance (N-1 decrements, then one sampling edge).
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    // Operand registers: the only sources of the adder, so its inputs stay
    // static for the whole settle window.
    logic [7:0] opa_q;
    logic [7:0] opb_q;
    logic       cin_q;
    logic [7:0] acc_q;
    logic [3:0] r_cnt;

    logic       r_out_valid;
    logic [7:0] r_result;
    logic       r_carry_out;
    logic [3:0] r_ovf_cnt;

    logic       w_accept;
    logic       w_settle_done;
    logic       w_hold_done;
    logic       w_clear_idle;
    logic       w_in_ready;
    logic [7:0] w_sum;
    logic       w_cout;

    SUM_RIZADO #(
        .PwrC (PwrC)
    ) u_sum (
        .i_a    (opa_q),
        .i_b    (opb_q),
        .i_cin  (cin_q),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // in_ready is gated by reset_L so it reads 0 while reset is held, and
    // becomes 1 as soon as reset releases (clear permitting).
    assign w_in_ready   = reset_L && (r_state == IDLE) && !clear;
    assign w_clear_idle = (r_state == IDLE) && clear;

    // State register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle event decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_settle_done = 1'b0;
        w_hold_done   = 1'b0;
        case (r_state)
            IDLE: begin
                // clear drops in_ready, so it wins over a simultaneous offer.
                if (in_valid && w_in_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (r_cnt == 4'd0) begin
                    w_settle_done = 1'b1;
                    w_state_nxt   = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_hold_done = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Capture operands on acceptance only; acc_mode substitutes the accumulator for op_a.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            opa_q <= 8'd0;
            opb_q <= 8'd0;
            cin_q <= 1'b0;
        end else if (w_accept) begin
            opa_q <= acc_mode ? acc_q : op_a;
            opb_q <= op_b;
            cin_q <= cin;
        end
    end

    // Settle countdown: preloaded at acceptance, decremented while settling.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= CNT_INIT;
        end else if ((r_state == SETTLE) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Output register: sample the settled adder, hold it until the handshake completes.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_result    <= 8'd0;
            r_carry_out <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_settle_done) begin
            r_result    <= w_sum;
            r_carry_out <= w_cout;
            r_out_valid <= 1'b1;
        end else if (w_hold_done) begin
            r_out_valid <= 1'b0;
        end
    end

    // Accumulator and saturating overflow count; clear only takes effect in IDLE.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            acc_q     <= 8'd0;
            r_ovf_cnt <= 4'd0;
        end else if (w_clear_idle) begin
            acc_q     <= 8'd0;
            r_ovf_cnt <= 4'd0;
        end else if (w_settle_done) begin
            acc_q <= w_sum;
            if (w_cout && (r_ovf_cnt != 4'd15)) begin
                r_ovf_cnt <= r_ovf_cnt + 4'd1;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign ovf_cnt   = r_ovf_cnt;

endmodule
